// File: rtl/ac_store_buffer.sv
// Posted write buffer: queues {addr, AC} pairs from the control unit and drains
// them to data memory over a req/ack handshake so the datapath never waits.
module ac_store_buffer #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 12,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   store_req,
    input  logic [WORD_SIZE-1:0]   ac_in,
    input  logic [ADDR_SIZE-1:0]   addr_in,
    input  logic                   clr_ovf,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   idle,
    output logic                   mem_wr_en,
    output logic [ADDR_SIZE-1:0]   mem_addr,
    output logic [WORD_SIZE-1:0]   mem_data,
    input  logic                   mem_ack
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [ADDR_SIZE-1:0] addr_q_r [DEPTH];
    logic [WORD_SIZE-1:0] data_q_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_next_s;
    logic                 overflow_r;
    logic                 pop_s;
    logic                 push_ok_s;
    logic                 drop_s;

    // Handshake decode: a full FIFO still accepts a push when the head leaves this cycle
    always_comb begin
        pop_s     = (state_r == ST_WRITE) && mem_ack;
        push_ok_s = store_req && ((count_r < DEPTH_C) || pop_s);
        drop_s    = store_req && !push_ok_s;
    end

    // Occupancy after this edge
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Drain FSM next state; IDLE looks at the registered count only
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (pop_s && (count_next_s == {CW{1'b0}})) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Entry storage, written at the tail on every accepted push
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            addr_q_r[wr_ptr_r] <= addr_in;
            data_q_r[wr_ptr_r] <= ac_in;
        end
    end

    // Control state; rst discards any write in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
            state_r    <= ST_IDLE;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
            count_r <= count_next_s;
            state_r <= state_next_s;
        end
    end

    // Outputs derive from registers only; bus reads zero while no request is up
    always_comb begin
        mem_wr_en = (state_r == ST_WRITE);
        full      = (count_r == DEPTH_C);
        empty     = (count_r == {CW{1'b0}});
        count     = count_r;
        overflow  = overflow_r;
        idle      = (count_r == {CW{1'b0}}) && (state_r == ST_IDLE);
        if (state_r == ST_WRITE) begin
            mem_addr = addr_q_r[rd_ptr_r];
            mem_data = data_q_r[rd_ptr_r];
        end else begin
            mem_addr = {ADDR_SIZE{1'b0}};
            mem_data = {WORD_SIZE{1'b0}};
        end
    end

endmodule

// File: tb/tb_ac_store_buffer.sv
// Self-checking bench for ac_store_buffer: directed scenarios plus randomized
// traffic against a queue-based reference of the posted-write behaviour.
module tb_ac_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, store_req, clr_ovf, mem_ack;
    logic [15:0] ac_in;
    logic [11:0] addr_in;
    logic        full, empty, overflow, idle, mem_wr_en;
    logic [2:0]  count;
    logic [11:0] mem_addr;
    logic [15:0] mem_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference: pending entries, whether a write is being presented, sticky overflow
    logic [27:0] mq[$];
    bit          m_busy = 1'b0;
    bit          m_ovf  = 1'b0;

    // Writes actually accepted by memory, with the cycle they happened
    logic [27:0] wlog[$];
    int          wcyc[$];

    always #5 clk = ~clk;

    ac_store_buffer #(.WORD_SIZE(16), .ADDR_SIZE(12), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .store_req(store_req), .ac_in(ac_in),
        .addr_in(addr_in), .clr_ovf(clr_ovf), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .idle(idle), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack)
    );

    // A write is presented once entries were waiting at the previous edge and
    // stays presented while entries remain; ack retires the oldest entry.
    always @(posedge clk) begin : ref_model
        int sz;
        bit pop, push;
        if (rst) begin
            mq.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            sz   = mq.size();
            pop  = m_busy && mem_ack;
            push = store_req && (sz < DEPTH || pop);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({addr_in, ac_in});
            if (store_req && !push) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_busy = m_busy ? (mq.size() > 0) : (sz > 0);
        end
    end

    always @(posedge clk) begin : mem_monitor
        cyc++;
        if (!rst && mem_wr_en && mem_ack) begin
            wlog.push_back({mem_addr, mem_data});
            wcyc.push_back(cyc);
        end
    end

    task automatic step(input logic r, input logic req, input logic [15:0] d,
                        input logic [11:0] a, input logic ack, input logic clr);
        rst = r; store_req = req; ac_in = d; addr_in = a; mem_ack = ack; clr_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({full, empty, overflow, idle, mem_wr_en} !== 5'b01010) begin
            n_bad++; $display("FAIL reset_flags got %b want 01010", {full, empty, overflow, idle, mem_wr_en});
        end
        n_cmp++;
        if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++;
        if ({mem_addr, mem_data} !== 28'h0) begin
            n_bad++; $display("FAIL reset_bus got %h want 0", {mem_addr, mem_data});
        end
        step(1'b0, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
    endtask

    task automatic test_single;
        wlog.delete(); wcyc.delete();
        step(1'b0, 1'b1, 16'h1234, 12'h010, 1'b1, 1'b0);
        n_cmp++;
        if ({empty, count, mem_wr_en} !== 5'b0_001_0) begin
            n_bad++; $display("FAIL single_k got empty=%b count=%0d wr=%b want 0/1/0", empty, count, mem_wr_en);
        end
        step(1'b0, 1'b0, 16'h0, 12'h0, 1'b1, 1'b0);
        n_cmp++;
        if ({mem_wr_en, mem_addr, mem_data} !== {1'b1, 12'h010, 16'h1234}) begin
            n_bad++; $display("FAIL single_req got wr=%b %h/%h want 1 010/1234", mem_wr_en, mem_addr, mem_data);
        end
        step(1'b0, 1'b0, 16'h0, 12'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 12'h0, 1'b1, 1'b0);
        n_cmp++;
        if ({mem_wr_en, idle} !== 2'b01) begin
            n_bad++; $display("FAIL single_done got wr=%b idle=%b want 0/1", mem_wr_en, idle);
        end
        n_cmp++;
        if (wlog.size() != 1 || wlog[0] !== 28'h010_1234) begin
            n_bad++; $display("FAIL single_writes got %0d writes want exactly 1 of 0101234", wlog.size());
        end
    endtask

    task automatic test_backpressure;
        logic [27:0] sent[$];
        logic [15:0] d;
        logic [11:0] a;
        wlog.delete(); wcyc.delete();
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom); a = 12'($urandom);
            sent.push_back({a, d});
            step(1'b0, 1'b1, d, a, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({mem_wr_en, mem_addr, mem_data} !== {1'b1, sent[0]}) begin
                n_bad++; $display("FAIL bp_stall%0d got wr=%b %h want 1 %h", i, mem_wr_en, {mem_addr, mem_data}, sent[0]);
            end
            step(1'b0, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 12'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0);
        n_cmp++;
        if (wlog.size() != 3 || wlog[0] !== sent[0] || wlog[1] !== sent[1] || wlog[2] !== sent[2]) begin
            n_bad++; $display("FAIL bp_order got %0d writes want 3 in push order", wlog.size());
        end else begin
            n_cmp++;
            if (wcyc[1] != wcyc[0] + 1 || wcyc[2] != wcyc[1] + 1) begin
                n_bad++; $display("FAIL bp_b2b got cycles %0d %0d %0d want consecutive", wcyc[0], wcyc[1], wcyc[2]);
            end
        end
        n_cmp++;
        if ({count, idle} !== 4'b000_1) begin
            n_bad++; $display("FAIL bp_drained got count=%0d idle=%b want 0/1", count, idle);
        end
    endtask

    task automatic test_full_overflow;
        logic [27:0] sent[$];
        logic [15:0] d;
        logic [11:0] a;
        wlog.delete(); wcyc.delete();
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom); a = 12'($urandom);
            if (i < 4) sent.push_back({a, d});
            step(1'b0, 1'b1, d, a, 1'b0, 1'b0);
            if (i == 3) begin
                n_cmp++;
                if ({full, count, overflow} !== 5'b1_100_0) begin
                    n_bad++; $display("FAIL full_4th got full=%b count=%0d ovf=%b want 1/4/0", full, count, overflow);
                end
            end
        end
        n_cmp++;
        if ({full, count, overflow} !== 5'b1_100_1) begin
            n_bad++; $display("FAIL full_drop got full=%b count=%0d ovf=%b want 1/4/1", full, count, overflow);
        end
        step(1'b0, 1'b1, 16'hDEAD, 12'hBEE, 1'b0, 1'b1);
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_clr_vs_drop got %b want 1", overflow); end
        step(1'b0, 1'b0, 16'h0, 12'h0, 1'b0, 1'b1);
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", overflow); end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 12'h0, 1'b1, 1'b0);
        n_cmp++;
        if (wlog.size() != 4 || wlog[0] !== sent[0] || wlog[1] !== sent[1] ||
            wlog[2] !== sent[2] || wlog[3] !== sent[3]) begin
            n_bad++; $display("FAIL full_drain got %0d writes want pushes 1-4 in order", wlog.size());
        end
    endtask

    task automatic test_push_pop_full;
        logic [27:0] sent[$];
        logic [15:0] d;
        logic [11:0] a;
        wlog.delete(); wcyc.delete();
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom); a = 12'($urandom);
            sent.push_back({a, d});
            step(1'b0, 1'b1, d, a, 1'b0, 1'b0);
        end
        d = 16'($urandom); a = 12'($urandom);
        sent.push_back({a, d});
        step(1'b0, 1'b1, d, a, 1'b1, 1'b0);
        n_cmp++;
        if ({full, count, overflow} !== 5'b1_100_0) begin
            n_bad++; $display("FAIL pp_full got full=%b count=%0d ovf=%b want 1/4/0", full, count, overflow);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 12'h0, 1'b1, 1'b0);
        n_cmp++;
        if (wlog.size() != 5 || wlog[4] !== sent[4] || wlog[0] !== sent[0]) begin
            n_bad++; $display("FAIL pp_order got %0d writes want 5 with new entry last", wlog.size());
        end
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL pp_idle got %b want 1", idle); end
    endtask

    task automatic test_wrap;
        logic [27:0] sent[$];
        logic [15:0] d;
        logic [11:0] a;
        logic        rq, ack;
        int          pushed;
        bit          done;
        pushed = 0;
        done = 1'b0;
        wlog.delete(); wcyc.delete();
        for (int c = 0; c < 2000 && !done; c++) begin
            rq  = (pushed < 10) && (mq.size() < DEPTH) && ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 2) == 0);
            d = 16'($urandom); a = 12'($urandom);
            if (rq) begin sent.push_back({a, d}); pushed++; end
            step(1'b0, rq, d, a, ack, 1'b0);
            n_cmp++;
            if (mem_wr_en !== m_busy || (m_busy && {mem_addr, mem_data} !== mq[0]) || count !== 3'(mq.size())) begin
                n_bad++; $display("FAIL wrap_cycle%0d got wr=%b %h cnt=%0d want wr=%b cnt=%0d",
                                  c, mem_wr_en, {mem_addr, mem_data}, count, m_busy, mq.size());
            end
            done = (pushed == 10) && (mq.size() == 0) && !m_busy;
        end
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL wrap_timeout got pushed=%0d pending=%0d want drained", pushed, mq.size()); end
        n_cmp++;
        if (wlog.size() != 10) begin
            n_bad++; $display("FAIL wrap_count got %0d writes want 10", wlog.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (wlog[i] !== sent[i]) begin
                    n_bad++; $display("FAIL wrap_write%0d got %h want %h", i, wlog[i], sent[i]);
                end
            end
        end
        n_cmp++;
        if ({overflow, idle} !== 2'b01) begin
            n_bad++; $display("FAIL wrap_end got ovf=%b idle=%b want 0/1", overflow, idle);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'($urandom), 12'($urandom), 1'b0, 1'b0);
        n_cmp++;
        if ({mem_wr_en, count} !== 4'b1_011) begin
            n_bad++; $display("FAIL rmid_pre got wr=%b count=%0d want 1/3", mem_wr_en, count);
        end
        step(1'b1, 1'b1, 16'hFFFF, 12'hFFF, 1'b1, 1'b0);
        n_cmp++;
        if ({mem_wr_en, count, empty, idle} !== 6'b0_000_11) begin
            n_bad++; $display("FAIL rmid_post got wr=%b count=%0d empty=%b idle=%b want 0/0/1/1",
                              mem_wr_en, count, empty, idle);
        end
        wlog.delete(); wcyc.delete();
        step(1'b0, 1'b1, 16'hA5C3, 12'h3C5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 12'h0, 1'b1, 1'b0);
        n_cmp++;
        if (wlog.size() != 1 || wlog[0] !== 28'h3C5_A5C3 || idle !== 1'b1) begin
            n_bad++; $display("FAIL rmid_after got %0d writes idle=%b want 1 write of 3C5A5C3, idle 1", wlog.size(), idle);
        end
    endtask

    initial begin
        rst = 1'b1; store_req = 1'b0; ac_in = 16'h0; addr_in = 12'h0; mem_ack = 1'b0; clr_ovf = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_full_overflow();
        test_push_pop_full();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ac_store_buffer.md
# ac_store_buffer

Posted write buffer that drains accumulator results to data memory. The control unit pushes a 16-bit AC value and its 12-bit target address with a one-cycle store request. The block queues the pair in a small FIFO and writes it to data memory through a req/ack handshake, so the datapath does not stall on slow memory. It is the read side of the accumulator register: it consumes the AC output instead of loading it.

## Interface
Parameters:
- WORD_SIZE, 16, data width; matches the accumulator.
- ADDR_SIZE, 12, memory address width.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; every register updates on its rising edge.
- rst  input  1  one clock; reset is synchronous and active-high (rst=1 clears state on the next rising clk edge).
- store_req  input  1  push strobe; one cycle per store.
- ac_in  input  WORD_SIZE  accumulator value to store.
- addr_in  input  ADDR_SIZE  target address.
- clr_ovf  input  1  clears the overflow flag.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  log2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; a push was dropped.
- idle  output  1  empty and FSM in IDLE; all stores have reached memory.
- mem_wr_en  output  1  write request to memory.
- mem_addr  output  ADDR_SIZE  write address.
- mem_data  output  WORD_SIZE  write data.
- mem_ack  input  1  memory accepted the write this cycle.

## Operation
- FIFO entries are {addr, data}, with wrapping read/write pointers and an explicit count register.
- Push:
  - Accepted when store_req=1 and (count<DEPTH or a pop occurs in the same cycle).
  - Otherwise the push is dropped, the FIFO is unchanged and overflow is set.
- overflow stays set until rst or clr_ovf. If clr_ovf and a dropped push occur in the same cycle, overflow stays set.
- Drain FSM has two states:
  - IDLE: mem_wr_en=0. Go to WRITE when count>0.
  - WRITE: mem_wr_en=1, with mem_addr and mem_data driven from the FIFO head.
  - In WRITE with mem_ack=1: pop the head. Stay in WRITE if the count after the pop is >0, otherwise go to IDLE.
  - In WRITE with mem_ack=0: hold the state and keep addr/data stable.
- mem_ack is ignored in IDLE.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH with no bubble.
- rst has priority over every other input:
  - Clears the pointers, count, overflow and FSM state, even in the middle of a write.
  - The entry in flight is discarded. Memory must tolerate the abandoned request.
- Reset values: mem_wr_en=0, mem_addr=0, mem_data=0, full=0, empty=1, count=0, overflow=0, idle=1.
- mem_addr and mem_data read 0 whenever mem_wr_en=0.

## Timing
- Push sampled at edge k means empty=0 and count=1 after edge k.
- The FSM enters WRITE at edge k+1, so mem_wr_en rises in the cycle after k+1. Store-to-request latency is 2 cycles.
- Ack sampled at edge m pops the head.
  - If entries remain, the next entry is presented right after edge m (back-to-back, 1 cycle per write with constant ack).
  - Otherwise mem_wr_en drops after edge m.
- Once mem_wr_en is high, mem_addr and mem_data must not change until the edge where ack is sampled.
- full, empty, count and idle are registered or derived from registers only. They have no combinational path from store_req or mem_ack.
- overflow updates at the edge that samples the dropped push.

## Test plan
- Reset and single store:
  - Stimulus: after rst, push ac_in=0x1234, addr_in=0x010; hold mem_ack=1.
  - Required: mem_wr_en high for exactly 1 cycle, starting 2 cycles after the push, with mem_addr=0x010 and mem_data=0x1234. Afterwards idle=1.
- Backpressure:
  - Stimulus: push 3 entries with mem_ack=0 for 5 cycles, then 1.
  - Required: the first entry is held stable for the whole stall. Writes then complete in push order on 3 consecutive cycles, and count returns to 0.
- Full and overflow:
  - Stimulus: with mem_ack=0, push 5 entries into DEPTH=4.
  - Required: full=1 after the 4th push, and the 5th is dropped with overflow=1. The 4 drained values match pushes 1-4. clr_ovf clears overflow.
- Push and pop together at full:
  - Stimulus: FIFO full, with mem_ack=1 and store_req=1 in the same cycle.
  - Required: the push is accepted, count stays 4, overflow stays 0, and the new entry drains last.
- Wrap-around:
  - Stimulus: 10 stores at random gaps with random ack delays.
  - Required: the memory sees all 10 address/data pairs in order, and the pointers wrap correctly twice.
- Reset mid-operation:
  - Stimulus: assert rst while in WRITE with 3 entries queued.
  - Required: after the edge, mem_wr_en=0, count=0, empty=1 and idle=1. A later push drains normally.
